// File: rtl/wfg_stim_ramp_pkg.sv
// Shared types and constants for the ramp stimulus generator.
package wfg_stim_ramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN_UP,
    ST_RUN_DOWN
  } state_e;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/wfg_stim_ramp_step.sv
// Combinational ramp step: next sample, next direction, and whether cur ends a period.
module wfg_stim_ramp_step
  import wfg_stim_ramp_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] min_val,
  input  logic [W-1:0] max_val,
  input  logic [W-1:0] inc,
  input  logic         mode,
  input  logic         dir,
  output logic [W-1:0] nxt,
  output logic         nxt_dir,
  output logic         last
);

  localparam int unsigned WX = W + 1;

  logic [WX-1:0] cur_x;
  logic [WX-1:0] max_x;
  logic [WX-1:0] sum_x;
  logic [WX-1:0] floor_x;

  // Widened arithmetic so cur+inc and min+inc can never wrap silently.
  always_comb begin
    cur_x   = {1'b0, cur};
    max_x   = {1'b0, max_val};
    sum_x   = cur_x + WX'(inc);
    floor_x = WX'(min_val) + WX'(inc);
    nxt     = sum_x[W-1:0];
    nxt_dir = dir;
    last    = 1'b0;
    if (mode == MODE_SAW) begin
      nxt_dir = DIR_UP;
      if (sum_x > max_x) begin
        nxt  = min_val;
        last = 1'b1;
      end
    end else if (dir == DIR_UP) begin
      if (sum_x >= max_x) begin
        nxt     = max_val;
        nxt_dir = DIR_DOWN;
      end
    end else begin
      // Landing on or below min closes the period and turns the ramp around.
      if (cur_x <= floor_x) begin
        nxt     = min_val;
        nxt_dir = DIR_UP;
        last    = 1'b1;
      end else begin
        nxt = cur - inc;
      end
    end
  end

endmodule

// File: rtl/wfg_stim_ramp.sv
// Sawtooth/triangle stimulus source driving an AXI-stream master port.
module wfg_stim_ramp
  import wfg_stim_ramp_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic                       wfg_axis_tlast_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
  input  logic                       ctrl_en_q_i,
  input  logic                       cfg_mode_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_min_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_max_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_inc_q_i
);

  localparam int unsigned W = AXIS_DATA_WIDTH;

  state_e         state_q, state_d;
  logic           mode_q, mode_d;
  logic           degen_q, degen_d;
  logic [W-1:0]   min_q, min_d;
  logic [W-1:0]   max_q, max_d;
  logic [W-1:0]   inc_q, inc_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;

  logic           start_c;
  logic           accept_c;
  logic [W-1:0]   adv_val_c;
  logic           adv_dir_c;
  logic [W-1:0]   ld_cur_c, ld_min_c, ld_max_c, ld_inc_c;
  logic           ld_mode_c, ld_dir_c;
  logic [W-1:0]   ld_nxt_unused_c;
  logic           ld_dir_unused_c;
  logic           ld_last_c;
  logic           cfg_degen_c;

  assign start_c     = (state_q == ST_IDLE) && ctrl_en_q_i;
  assign accept_c    = valid_q && wfg_axis_tready_i;
  assign cfg_degen_c = (cfg_inc_q_i == '0) || (cfg_min_q_i >= cfg_max_q_i);

  // Advance the currently presented sample.
  wfg_stim_ramp_step #(.W(W)) u_step_adv (
    .cur     (data_q),
    .min_val (min_q),
    .max_val (max_q),
    .inc     (inc_q),
    .mode    (mode_q),
    .dir     (state_q == ST_RUN_DOWN ? DIR_DOWN : DIR_UP),
    .nxt     (adv_val_c),
    .nxt_dir (adv_dir_c),
    .last    ()
  );

  // Candidate sample about to be loaded: either the first after enable or the advanced one.
  always_comb begin
    ld_cur_c  = start_c ? cfg_min_q_i  : adv_val_c;
    ld_min_c  = start_c ? cfg_min_q_i  : min_q;
    ld_max_c  = start_c ? cfg_max_q_i  : max_q;
    ld_inc_c  = start_c ? cfg_inc_q_i  : inc_q;
    ld_mode_c = start_c ? cfg_mode_q_i : mode_q;
    ld_dir_c  = start_c ? DIR_UP       : adv_dir_c;
  end

  // Period-end flag is evaluated on the value being loaded so tlast is registered with tdata.
  wfg_stim_ramp_step #(.W(W)) u_step_ld (
    .cur     (ld_cur_c),
    .min_val (ld_min_c),
    .max_val (ld_max_c),
    .inc     (ld_inc_c),
    .mode    (ld_mode_c),
    .dir     (ld_dir_c),
    .nxt     (ld_nxt_unused_c),
    .nxt_dir (ld_dir_unused_c),
    .last    (ld_last_c)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    degen_d = degen_q;
    min_d   = min_q;
    max_d   = max_q;
    inc_d   = inc_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q_i) begin
          mode_d  = cfg_mode_q_i;
          degen_d = cfg_degen_c;
          min_d   = cfg_min_q_i;
          max_d   = cfg_max_q_i;
          inc_d   = cfg_inc_q_i;
          data_d  = cfg_min_q_i;
          valid_d = 1'b1;
          last_d  = cfg_degen_c || ld_last_c;
          state_d = ST_RUN_UP;
        end
      end
      ST_RUN_UP, ST_RUN_DOWN: begin
        if (accept_c || !valid_q) begin
          if (!ctrl_en_q_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (degen_q) begin
            data_d  = min_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = ST_RUN_UP;
          end else begin
            data_d  = adv_val_c;
            valid_d = 1'b1;
            last_d  = ld_last_c;
            state_d = (adv_dir_c == DIR_DOWN) ? ST_RUN_DOWN : ST_RUN_UP;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SAW;
      degen_q <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      inc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      degen_q <= degen_d;
      min_q   <= min_d;
      max_q   <= max_d;
      inc_q   <= inc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign wfg_axis_tvalid_o = valid_q;
  assign wfg_axis_tlast_o  = last_q;
  assign wfg_axis_tdata_o  = data_q;

endmodule

// File: tb/tb_wfg_stim_ramp.sv
// Directed bench for the ramp stimulus source.
module tb_wfg_stim_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        tready;
  logic        tvalid;
  logic        tlast;
  logic [31:0] tdata;
  logic        en;
  logic        mode;
  logic [31:0] cmin;
  logic [31:0] cmax;
  logic [31:0] cinc;

  int checks   = 0;
  int failures = 0;

  wfg_stim_ramp #(.AXIS_DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tlast_o  (tlast),
    .wfg_axis_tdata_o  (tdata),
    .ctrl_en_q_i       (en),
    .cfg_mode_q_i      (mode),
    .cfg_min_q_i       (cmin),
    .cfg_max_q_i       (cmax),
    .cfg_inc_q_i       (cinc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shut the generator down with tready high and confirm it goes quiet.
  task automatic stop_stream(input string name);
    en = 1'b0;
    tready = 1'b1;
    tick();
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL %s_stop: tvalid=%b tlast=%b, required 0 0", name, tvalid, tlast);
    end
    tick();
  endtask

  task automatic start_stream(input logic m, input logic [31:0] lo, input logic [31:0] hi,
                              input logic [31:0] step);
    mode = m; cmin = lo; cmax = hi; cinc = step;
    tready = 1'b1;
    en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tready = 1'b0;
    mode = 1'b0; cmin = '0; cmax = '0; cinc = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'd0) begin
      failures++;
      $display("FAIL reset: tvalid=%b tlast=%b tdata=%0d, required 0 0 0", tvalid, tlast, tdata);
    end
  endtask

  task automatic test_saw();
    logic [31:0] exp_d [8] = '{0, 3, 6, 9, 0, 3, 6, 9};
    logic        exp_l [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    start_stream(1'b0, 32'd0, 32'd10, 32'd3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_d[i] || tlast !== exp_l[i]) begin
        failures++;
        $display("FAIL saw[%0d]: v=%b d=%0d l=%b, required 1 %0d %b",
                 i, tvalid, tdata, tlast, exp_d[i], exp_l[i]);
      end
      tick();
    end
    stop_stream("saw");
  endtask

  task automatic test_triangle();
    logic [31:0] exp_d [13] = '{2, 4, 6, 8, 6, 4, 2, 4, 6, 8, 6, 4, 2};
    logic        exp_l [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    start_stream(1'b1, 32'd2, 32'd8, 32'd2);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_d[i] || tlast !== exp_l[i]) begin
        failures++;
        $display("FAIL tri[%0d]: v=%b d=%0d l=%b, required 1 %0d %b",
                 i, tvalid, tdata, tlast, exp_d[i], exp_l[i]);
      end
      tick();
    end
    stop_stream("tri");
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [7] = '{0, 3, 6, 9, 0, 3, 6};
    logic        exp_l [7] = '{0, 0, 0, 1, 0, 0, 0};
    start_stream(1'b0, 32'd0, 32'd10, 32'd3);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          checks++;
          if (tvalid !== 1'b1 || tdata !== 32'd9 || tlast !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d]: v=%b d=%0d l=%b, required 1 9 1",
                     k, tvalid, tdata, tlast);
          end
        end
        tready = 1'b1;
      end
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_d[i] || tlast !== exp_l[i]) begin
        failures++;
        $display("FAIL bp[%0d]: v=%b d=%0d l=%b, required 1 %0d %b",
                 i, tvalid, tdata, tlast, exp_d[i], exp_l[i]);
      end
      tick();
    end
    stop_stream("bp");
  endtask

  task automatic test_overflow();
    start_stream(1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'hFFFF_FFF0 || tlast !== 1'b1) begin
        failures++;
        $display("FAIL ovf[%0d]: v=%b d=%h l=%b, required 1 fffffff0 1",
                 i, tvalid, tdata, tlast);
      end
      tick();
    end
    stop_stream("ovf");
  endtask

  task automatic test_disable_pending();
    start_stream(1'b0, 32'd0, 32'd10, 32'd3);
    tick(); tick();
    // Presenting 6 now; stall it and drop enable together.
    tready = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'd6 || tlast !== 1'b0) begin
        failures++;
        $display("FAIL dis_hold[%0d]: v=%b d=%0d l=%b, required 1 6 0",
                 k, tvalid, tdata, tlast);
      end
    end
    tready = 1'b1;
    tick();
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL dis_drop: v=%b l=%b, required 0 0", tvalid, tlast);
    end
    tick();
    checks++;
    if (tvalid !== 1'b0) begin
      failures++;
      $display("FAIL dis_idle: v=%b, required 0", tvalid);
    end
    start_stream(1'b0, 32'd5, 32'd20, 32'd1);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 32'd5 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL reen: v=%b d=%0d l=%b, required 1 5 0", tvalid, tdata, tlast);
    end
    tick();
    checks++;
    if (tvalid !== 1'b1 || tdata !== 32'd6) begin
      failures++;
      $display("FAIL reen2: v=%b d=%0d, required 1 6", tvalid, tdata);
    end
    stop_stream("reen");
  endtask

  task automatic test_degenerate();
    start_stream(1'b0, 32'd7, 32'd20, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'd7 || tlast !== 1'b1) begin
        failures++;
        $display("FAIL deg_inc0[%0d]: v=%b d=%0d l=%b, required 1 7 1",
                 i, tvalid, tdata, tlast);
      end
      tick();
    end
    stop_stream("deg_inc0");
    start_stream(1'b1, 32'd7, 32'd3, 32'd2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'd7 || tlast !== 1'b1) begin
        failures++;
        $display("FAIL deg_minmax[%0d]: v=%b d=%0d l=%b, required 1 7 1",
                 i, tvalid, tdata, tlast);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'd0) begin
      failures++;
      $display("FAIL mid_rst: v=%b l=%b d=%0d, required 0 0 0", tvalid, tlast, tdata);
    end
    rst = 1'b0;
    en = 1'b0;
    tick();
    checks++;
    if (tvalid !== 1'b0) begin
      failures++;
      $display("FAIL post_rst: v=%b, required 0", tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_triangle();
    test_backpressure();
    test_overflow();
    test_disable_pending();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
